uart_cmd_sequencer: RTL and testbench
=====================================

Name: uart_cmd_sequencer

Overview:
- Sequences a UART byte receiver that has an rdy/clr_rdy handshake: consumes each received byte, hunts for a sync byte, and assembles fixed-length command frames.
- Frame format: SYNC, CMD, DATA_HI, DATA_LO, plus a CHK byte when the optional feature is enabled.
- Presents a completed {cmd, data} to the Segway control logic with a level cmd_rdy / clr_cmd_rdy handshake.
- Also flags inter-byte timeout and overrun.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
TO_CYCLES, 100000, clk cycles allowed between bytes inside a frame (about 4 byte times at 50 MHz / 19200 baud)
TO_W, 17, timeout counter width; must satisfy 2**TO_W > TO_CYCLES

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
byte_rdy  input  1  receiver holds a valid byte (receiver rdy)
rx_data  input  8  receiver byte, valid while byte_rdy=1
clr_rdy  output  1  byte consumed; drives receiver clr_rdy
clr_cmd_rdy  input  1  consumer acknowledges cmd/data
cmd_rdy  output  1  level; valid command held on cmd/data
cmd  output  8  command byte
data  output  16  {DATA_HI, DATA_LO}
to_err  output  1  1-cycle pulse: inter-byte timeout aborted a frame
chk_err  output  1  1-cycle pulse: checksum mismatch (0 when feature is out)
ovr  output  1  sticky: complete frame dropped while cmd_rdy=1

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - State = SYNC_HUNT.
  - cmd_rdy, to_err, chk_err, ovr = 0.
  - cmd = 8'h00, data = 16'h0000.
  - Timeout counter = 0; byte shadow registers = 0.
- Byte consumption:
  - clr_rdy = byte_rdy, combinational, in every state. Every presented byte is consumed at the edge where it is sampled.
  - Because the receiver's rdy is registered, a byte is never taken twice.
- States: SYNC_HUNT, GET_CMD, GET_DHI, GET_DLO, GET_CHK (GET_CHK exists only with the feature).
  - SYNC_HUNT:
    - byte_rdy with rx_data==SYNC_BYTE -> GET_CMD.
    - Any other byte is discarded; stay.
    - The timeout counter is held at 0.
  - GET_CMD / GET_DHI / GET_DLO: byte_rdy -> capture into a shadow register and advance to the next state.
    - A SYNC_BYTE value here is ordinary data.
  - The last state (GET_DLO without the feature, GET_CHK with it) -> frame complete on byte_rdy; return to SYNC_HUNT.
- Timeout:
  - Counter clears on every accepted byte and increments each cycle while not in SYNC_HUNT.
  - When the counter reaches TO_CYCLES-1 with no byte_rdy that cycle: go to SYNC_HUNT, pulse to_err for 1 cycle, discard the partial frame.
  - If byte_rdy arrives in that same cycle, the byte wins and there is no timeout.
- Frame completion, registered; outputs update the cycle after the final byte edge:
  - If cmd_rdy==0, or clr_cmd_rdy==1 in the completion cycle: load cmd/data from the shadows and set cmd_rdy=1.
  - Otherwise (cmd_rdy==1, no ack): drop the frame, set ovr=1, leave cmd/data unchanged.
- cmd_rdy handshake:
  - clr_cmd_rdy clears cmd_rdy and ovr on the next edge.
  - If completion happens in the same cycle, cmd_rdy stays 1 with the new data and ovr stays 0.
  - cmd/data are stable whenever cmd_rdy=1.
- Reset mid-frame: immediately returns to SYNC_HUNT and clears all outputs; the partial frame is lost.
- Latency: the final byte sampled at edge N gives cmd_rdy=1 after edge N+1.

Optional Feature:
- Macro: UART_CMD_CHKSUM_EN.
- Defined:
  - Adds state GET_CHK after GET_DLO.
  - The frame is good when (CMD + DHI + DLO + CHK) mod 256 == 8'h00.
  - A good frame completes as above.
  - A mismatch -> SYNC_HUNT, chk_err 1-cycle pulse, cmd/data/cmd_rdy/ovr untouched.
- Undefined:
  - The frame completes at GET_DLO.
  - chk_err is tied to 0.
  - No GET_CHK state logic is synthesized.

Test Plan:
- Basic frame: bytes 8'h3C, A5, 10, 12, 34, plus 8'hAA if the feature is in -> 3C discarded; cmd_rdy=1 with cmd=8'h10, data=16'h1234; each clr_rdy is a single-cycle pulse coinciding with its byte_rdy.
- Timeout: A5, 10, then no byte for TO_CYCLES cycles -> to_err pulses once, cmd_rdy stays 0; a following full frame A5, 20, 00, 01 (+DF) is received cleanly.
- Overrun: two complete frames with no clr_cmd_rdy -> first frame retained, ovr=1; then clr_cmd_rdy -> cmd_rdy=0, ovr=0.
- Simultaneous ack and completion: clr_cmd_rdy asserted in the completion cycle of frame 2 -> cmd_rdy stays 1, frame-2 data loaded, ovr=0.
- Checksum (feature in): A5, 10, 12, 34, AB -> chk_err pulse, cmd_rdy unchanged; A5 embedded as a data byte (A5, 01, A5, 00, 5A) is accepted as data=16'hA500.
- Reset mid-frame: assert rst after A5, 10 -> all outputs 0 asynchronously; after release, a frame starting with 12 is ignored until A5 is seen.

Source files
------------

// File: rtl/uart_cmd_sequencer.sv
// UART command-frame sequencer: hunts SYNC_BYTE, assembles {cmd, data}, flags timeout/overrun.
// Optional checksum byte stage enabled by defining UART_CMD_CHKSUM_EN.
module uart_cmd_sequencer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TO_CYCLES = 100000,
  parameter int         TO_W      = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        to_err,
  output logic        chk_err,
  output logic        ovr
);

  typedef enum logic [2:0] {
    SYNC_HUNT, GET_CMD, GET_DHI, GET_DLO
`ifdef UART_CMD_CHKSUM_EN
    , GET_CHK
`endif
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [7:0]      cmd_sh_q, cmd_sh_d, dhi_q, dhi_d, dlo_q, dlo_d;
  logic            done_q, done_d;
  logic            cmd_rdy_q, cmd_rdy_d, ovr_q, ovr_d, to_err_q, to_err_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [15:0]     data_q, data_d;
  logic            frame_ok;
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0]      chk_q, chk_d, sum;
  logic            chk_err_q, chk_err_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_sh_d  = cmd_sh_q;
    dhi_d     = dhi_q;
    dlo_d     = dlo_q;
    done_d    = 1'b0;
    cmd_rdy_d = cmd_rdy_q;
    ovr_d     = ovr_q;
    to_err_d  = 1'b0;
    cmd_d     = cmd_q;
    data_d    = data_q;
`ifdef UART_CMD_CHKSUM_EN
    chk_d     = chk_q;
    sum       = cmd_sh_q + dhi_q + dlo_q + chk_q;
    frame_ok  = (sum == 8'h00);
    chk_err_d = done_q && !frame_ok;
`else
    frame_ok  = 1'b1;
`endif

    if (state_q == SYNC_HUNT) begin
      cnt_d = '0;
      if (byte_rdy && rx_data == SYNC_BYTE) state_d = GET_CMD;
    end else if (byte_rdy) begin
      cnt_d = '0;
      case (state_q)
        GET_CMD: begin cmd_sh_d = rx_data; state_d = GET_DHI; end
        GET_DHI: begin dhi_d = rx_data; state_d = GET_DLO; end
        GET_DLO: begin
          dlo_d = rx_data;
`ifdef UART_CMD_CHKSUM_EN
          state_d = GET_CHK;
        end
        GET_CHK: begin
          chk_d = rx_data;
`endif
          state_d = SYNC_HUNT;
          done_d  = 1'b1;
        end
        default: state_d = SYNC_HUNT;
      endcase
    end else if (cnt_q == TO_LAST) begin
      // A byte landing in the expiry cycle wins; only a silent cycle aborts.
      state_d  = SYNC_HUNT;
      cnt_d    = '0;
      to_err_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
      ovr_d     = 1'b0;
    end
    // Completion is evaluated one cycle after the final byte so an ack in that cycle frees the slot.
    if (done_q && frame_ok) begin
      if (!cmd_rdy_q || clr_cmd_rdy) begin
        cmd_rdy_d = 1'b1;
        cmd_d     = cmd_sh_q;
        data_d    = {dhi_q, dlo_q};
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SYNC_HUNT;
      cnt_q     <= '0;
      cmd_sh_q  <= '0;
      dhi_q     <= '0;
      dlo_q     <= '0;
      done_q    <= 1'b0;
      cmd_rdy_q <= 1'b0;
      ovr_q     <= 1'b0;
      to_err_q  <= 1'b0;
      cmd_q     <= '0;
      data_q    <= '0;
`ifdef UART_CMD_CHKSUM_EN
      chk_q     <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_sh_q  <= cmd_sh_d;
      dhi_q     <= dhi_d;
      dlo_q     <= dlo_d;
      done_q    <= done_d;
      cmd_rdy_q <= cmd_rdy_d;
      ovr_q     <= ovr_d;
      to_err_q  <= to_err_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
`ifdef UART_CMD_CHKSUM_EN
      chk_q     <= chk_d;
      chk_err_q <= chk_err_d;
`endif
    end
  end

  assign clr_rdy = byte_rdy;
  assign cmd_rdy = cmd_rdy_q;
  assign cmd     = cmd_q;
  assign data    = data_q;
  assign to_err  = to_err_q;
  assign ovr     = ovr_q;
`ifdef UART_CMD_CHKSUM_EN
  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench for uart_cmd_sequencer; honours UART_CMD_CHKSUM_EN like the design.
module tb_uart_cmd_sequencer;

  localparam int TO_CYCLES = 40;
  localparam logic [1:0] EV_FRAME = 2'd0, EV_TO = 2'd1, EV_CHK = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  cmd;
    logic [15:0] data;
  } ev_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        byte_rdy = 1'b0, clr_cmd_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rdy, cmd_rdy, to_err, chk_err, ovr;
  logic [7:0]  cmd;
  logic [15:0] data;

  int  checks = 0, errors = 0;
  ev_t exp_q[$];

  uart_cmd_sequencer #(.SYNC_BYTE(8'hA5), .TO_CYCLES(TO_CYCLES), .TO_W(17)) dut (
    .clk(clk), .rst(rst), .byte_rdy(byte_rdy), .rx_data(rx_data), .clr_rdy(clr_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .to_err(to_err), .chk_err(chk_err), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] c, input logic [15:0] d);
    ev_t e;
    e.kind = k; e.cmd = c; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); byte_rdy = 1'b1; rx_data = b;
    @(negedge clk); byte_rdy = 1'b0;
  endtask

  // Full frame; the checksum byte is only sent when the feature is compiled in.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo);
    logic [7:0] s;
    s = c + hi + lo;
    send_byte(8'hA5); send_byte(c); send_byte(hi);
`ifdef UART_CMD_CHKSUM_EN
    send_byte(lo); send_byte(8'h00 - s);
`else
    send_byte(lo);
`endif
  endtask

  task automatic ack();
    @(negedge clk); clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0;
  endtask

  // Monitor: every output event is matched against the head of the expectation queue.
  initial begin
    logic        prev_rdy = 1'b0;
    logic [23:0] prev_cd = '0;
    ev_t         got, e;
    forever begin
      @(posedge clk); #1;
      chk("clr_rdy", {31'd0, clr_rdy}, {31'd0, byte_rdy});
      got = '0;
      if (to_err) got.kind = EV_TO;
      else if (chk_err) got.kind = EV_CHK;
      else if (cmd_rdy && (!prev_rdy || {cmd, data} != prev_cd)) begin
        got.kind = EV_FRAME; got.cmd = cmd; got.data = data;
      end else got.kind = 2'd3;
      if (got.kind != 2'd3) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event actual=%h expected=none @%0t", got, $time);
        end else begin
          e = exp_q.pop_front();
          chk("ev_kind", {30'd0, got.kind}, {30'd0, e.kind});
          if (e.kind == EV_FRAME) chk("ev_cmd_data", {8'd0, got.cmd, got.data}, {8'd0, e.cmd, e.data});
        end
      end
      prev_rdy = cmd_rdy;
      prev_cd  = {cmd, data};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk); #1;
    chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("rst_cmd_data", {8'd0, cmd, data}, 32'd0);
    chk("rst_flags", {29'd0, ovr, to_err, chk_err}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Basic frame with leading junk byte and latency check
    push(EV_FRAME, 8'h10, 16'h1234);
    send_byte(8'h3C);
    send_frame(8'h10, 8'h12, 8'h34);
    chk("lat_edge_n", {31'd0, cmd_rdy}, 32'd0);
    @(posedge clk); #1;
    chk("lat_edge_n1", {31'd0, cmd_rdy}, 32'd1);
    chk("basic_data", {8'd0, cmd, data}, 32'h00101234);
    ack();
    chk("ack_clears", {31'd0, cmd_rdy}, 32'd0);

    // Inter-byte timeout then a clean frame
    push(EV_TO, 8'h00, 16'h0000);
    send_byte(8'hA5); send_byte(8'h10);
    repeat (TO_CYCLES + 20) @(negedge clk);
    chk("to_no_cmd", {31'd0, cmd_rdy}, 32'd0);
    push(EV_FRAME, 8'h20, 16'h0001);
    send_frame(8'h20, 8'h00, 8'h01);
    @(posedge clk); #1;
    ack();

    // Overrun: second frame dropped, first retained
    push(EV_FRAME, 8'h30, 16'h5678);
    send_frame(8'h30, 8'h56, 8'h78);
    send_frame(8'h40, 8'h9A, 8'hBC);
    @(posedge clk); #1;
    chk("ovr_set", {31'd0, ovr}, 32'd1);
    chk("ovr_retain", {8'd0, cmd, data}, 32'h00305678);
    ack();
    chk("ovr_ack_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("ovr_ack_ovr", {31'd0, ovr}, 32'd0);

    // Ack coinciding with completion of the second frame
    push(EV_FRAME, 8'h50, 16'h1111);
    send_frame(8'h50, 8'h11, 8'h11);
    push(EV_FRAME, 8'h60, 16'h2222);
    send_frame(8'h60, 8'h22, 8'h22);
    clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0;
    chk("simul_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("simul_ovr", {31'd0, ovr}, 32'd0);
    chk("simul_data", {8'd0, cmd, data}, 32'h00602222);
    ack();

`ifdef UART_CMD_CHKSUM_EN
    // Bad checksum
    push(EV_CHK, 8'h00, 16'h0000);
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
    @(posedge clk); #1;
    chk("chk_no_cmd", {31'd0, cmd_rdy}, 32'd0);
`endif
    // Sync value embedded as data
    push(EV_FRAME, 8'h01, 16'hA500);
    send_frame(8'h01, 8'hA5, 8'h00);
    @(posedge clk); #1;
    chk("embedded_sync", {8'd0, cmd, data}, 32'h0001A500);

    // Reset mid-frame with cmd_rdy and ovr both set
    send_frame(8'h71, 8'h33, 8'h33);
    send_byte(8'hA5); send_byte(8'h10);
    chk("pre_rst_ovr", {30'd0, cmd_rdy, ovr}, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags", {30'd0, cmd_rdy, ovr}, 32'd0);
    chk("async_rst_data", {8'd0, cmd, data}, 32'd0);
    @(negedge clk); rst = 1'b0;
    send_byte(8'h12); send_byte(8'h80); send_byte(8'h44); send_byte(8'h55);
    repeat (3) @(negedge clk);
    chk("post_rst_ignored", {31'd0, cmd_rdy}, 32'd0);
    push(EV_FRAME, 8'h81, 16'h6677);
    send_frame(8'h81, 8'h66, 8'h77);

    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
